// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Provides the FSM state enum, display geometry and default idle word.
package sseg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sseg_arb_state_t;

    localparam int SSEG_DIGITS = 4;
    localparam int SSEG_WORD_W = 16;

    localparam logic [SSEG_WORD_W-1:0] SSEG_IDLE_DATA = 16'h0000;

endpackage

// File: rtl/sseg_rr_pick.sv
// Round-robin picker: first set request searching upward from i_ptr+1 with wrap.
// Ports: i_req (requests), i_ptr (search base), i_excl (skip the base index
// itself), o_found (any candidate), o_idx (chosen index).
module sseg_rr_pick
    import sseg_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    input  logic            i_excl,
    output logic            o_found,
    output logic [PW-1:0]   o_idx
);

    logic [PW-1:0] w_j;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_j     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_j = PW'((int'(i_ptr) + k) % NREQ);
            if (i_req[w_j] && !(i_excl && (k == NREQ))) begin
                o_found = 1'b1;
                o_idx   = w_j;
            end
        end
    end

endmodule

// File: rtl/sseg_arbiter.sv
// Round-robin owner arbiter with minimum dwell for the shared sseg display.
// Ports: clk, clear (sync active-low), req, req_data -> grant, owner, busy,
// display_data. Optional urgent-source preemption via SSEG_ARB_PRIO_EN.
module sseg_arbiter
    import sseg_pkg::*;
#(
    parameter int                     NREQ         = 4,
    parameter int                     DWELL_CYCLES = 50_000_000,
    parameter logic [SSEG_WORD_W-1:0] IDLE_DATA    = SSEG_IDLE_DATA
) (
    input  logic                        clk,
    input  logic                        clear,
    input  logic [NREQ-1:0]             req,
    input  logic [SSEG_WORD_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]             grant,
    output logic [$clog2(NREQ)-1:0]     owner,
    output logic                        busy,
    output logic [SSEG_WORD_W-1:0]      display_data
);

    localparam int            OW         = $clog2(NREQ);
    localparam int            CW         = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [OW-1:0] PTR_RST    = OW'(NREQ - 1);

    sseg_arb_state_t          r_state;
    logic [NREQ-1:0]          r_grant;
    logic [OW-1:0]            r_owner;
    logic [OW-1:0]            r_ptr;
    logic                     r_busy;
    logic [SSEG_WORD_W-1:0]   r_data;
    logic [CW-1:0]            r_cnt;

    logic [SSEG_WORD_W-1:0]   w_words [NREQ];
    logic                     w_hold;
    logic                     w_own_req;
    logic [NREQ-1:0]          w_pick_req;
    logic [OW-1:0]            w_base;
    logic                     w_excl;
    logic                     w_found;
    logic [OW-1:0]            w_idx;
    logic                     w_take;
    logic                     w_drop;
    logic                     w_preempt;

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign w_words[g] = req_data[g*SSEG_WORD_W +: SSEG_WORD_W];
    end

    assign w_hold     = (r_state == HOLD);
    assign w_own_req  = req[r_owner];
    assign w_pick_req = w_hold ? (req & ~r_grant) : req;

`ifdef SSEG_ARB_PRIO_EN
    logic r_preempt;

    assign w_preempt = w_hold && req[0] && (r_owner != '0) && w_own_req;
    // While req[0] holds a preempted display, start the search at the
    // displaced owner itself so it resumes first.
    assign w_base = r_preempt ? ((r_ptr == '0) ? PTR_RST : r_ptr - OW'(1))
                              : r_ptr;
    assign w_excl = w_hold && !r_preempt;
`else
    assign w_preempt = 1'b0;
    assign w_base    = r_ptr;
    assign w_excl    = w_hold;
`endif

    sseg_rr_pick #(
        .NREQ (NREQ),
        .PW   (OW)
    ) u_pick (
        .i_req   (w_pick_req),
        .i_ptr   (w_base),
        .i_excl  (w_excl),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    // New owner: from IDLE, on release, or on dwell expiry under contention.
    assign w_take = w_found && (!w_hold || !w_own_req || (r_cnt == '0));
    assign w_drop = w_hold && !w_own_req && !w_found;

    always_ff @(posedge clk) begin
        if (!clear) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= PTR_RST;
            r_busy  <= 1'b0;
            r_data  <= IDLE_DATA;
            r_cnt   <= '0;
`ifdef SSEG_ARB_PRIO_EN
            r_preempt <= 1'b0;
`endif
        end else if (w_preempt) begin
            r_grant <= NREQ'(1);
            r_owner <= '0;
            r_cnt   <= DWELL_LOAD;
            r_data  <= w_words[0];
`ifdef SSEG_ARB_PRIO_EN
            r_preempt <= 1'b1;
`endif
        end else if (w_take) begin
            r_state <= HOLD;
            r_grant <= NREQ'(1) << w_idx;
            r_owner <= w_idx;
            r_ptr   <= w_idx;
            r_busy  <= 1'b1;
            r_cnt   <= DWELL_LOAD;
            r_data  <= w_words[w_idx];
`ifdef SSEG_ARB_PRIO_EN
            r_preempt <= 1'b0;
`endif
        end else if (w_drop) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_busy  <= 1'b0;
            r_data  <= IDLE_DATA;
`ifdef SSEG_ARB_PRIO_EN
            r_preempt <= 1'b0;
`endif
        end else if (w_hold) begin
            r_data <= w_words[r_owner];
            // Expiry with nobody waiting just starts a fresh dwell.
            r_cnt  <= (r_cnt == '0) ? DWELL_LOAD : r_cnt - CW'(1);
        end
    end

    assign grant        = r_grant;
    assign owner        = r_owner;
    assign busy         = r_busy;
    assign display_data = r_data;

endmodule

// File: tb/tb_sseg_arbiter.sv
// Self-checking bench for sseg_arbiter (NREQ=4, DWELL_CYCLES=8).
// Directed scenarios plus random traffic against a behavioural owner model.
module tb_sseg_arbiter;

    localparam int NREQ  = 4;
    localparam int DWELL = 8;

    logic        clk = 1'b0;
    logic        clear;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] display_data;

    logic [15:0] rd [4];

    assign req_data = {rd[3], rd[2], rd[1], rd[0]};

    always #5 clk = ~clk;

    sseg_arbiter #(
        .NREQ         (NREQ),
        .DWELL_CYCLES (DWELL),
        .IDLE_DATA    (16'h0000)
    ) dut (
        .clk          (clk),
        .clear        (clear),
        .req          (req),
        .req_data     (req_data),
        .grant        (grant),
        .owner        (owner),
        .busy         (busy),
        .display_data (display_data)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: owner index (-1 = nobody), cycles held since grant edge,
    // last round-robin winner, preempted-hold flag, word on the display.
    int          m_own;
    int          m_age;
    int          m_ptr;
    bit          m_pre;
    logic [15:0] m_data;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        assert (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    function automatic bit rbit(input logic [3:0] v, input int k);
        logic [3:0] s;
        s = v >> k;
        return s[0];
    endfunction

    // Candidate order: after the pointer with wrap, or starting at the
    // pointer itself when resuming a preempted source; never the owner.
    function automatic int pick(input logic [3:0] r, input int own,
                                input int ptr, input bit pre);
        for (int off = 0; off < NREQ; off++) begin
            int k;
            k = pre ? (ptr + off) % NREQ : (ptr + 1 + off) % NREQ;
            if (k != own && rbit(r, k)) return k;
        end
        return -1;
    endfunction

    task automatic give(input int k);
        m_own  = k;
        m_ptr  = k;
        m_age  = 0;
        m_pre  = 0;
        m_data = rd[k[1:0]];
    endtask

    task automatic model_step();
        int nx;
        if (!clear) begin
            m_own  = -1;
            m_ptr  = NREQ - 1;
            m_age  = 0;
            m_pre  = 0;
            m_data = 16'h0000;
        end else if (m_own < 0) begin
            nx = pick(req, -1, m_ptr, 1'b0);
            if (nx >= 0) give(nx);
        end else begin
`ifdef SSEG_ARB_PRIO_EN
            if (req[0] && m_own != 0 && rbit(req, m_own)) begin
                m_own  = 0;
                m_age  = 0;
                m_pre  = 1;
                m_data = rd[0];
                return;
            end
`endif
            nx = pick(req, m_own, m_ptr, m_pre);
            if (!rbit(req, m_own)) begin
                if (nx >= 0) give(nx);
                else begin
                    m_own  = -1;
                    m_pre  = 0;
                    m_data = 16'h0000;
                end
            end else if (m_age == DWELL - 1 && nx >= 0) begin
                give(nx);
            end else begin
                m_age  = (m_age == DWELL - 1) ? 0 : m_age + 1;
                m_data = rd[m_own[1:0]];
            end
        end
    endtask

    task automatic tick(input string tag);
        logic [3:0] eg;
        logic [1:0] eo;
        model_step();
        @(posedge clk);
        #1;
        eg = (m_own < 0) ? 4'b0000 : (4'b0001 << m_own[1:0]);
        eo = (m_own < 0) ? 2'd0 : m_own[1:0];
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".owner"}, 32'(owner), 32'(eo));
        chk({tag, ".busy"}, 32'(busy), 32'(m_own >= 0));
        chk({tag, ".data"}, 32'(display_data), 32'(m_data));
    endtask

    task automatic do_reset();
        clear = 1'b0;
        req   = 4'b0000;
        tick("rst");
        clear = 1'b1;
    endtask

    int          rot [4];
    logic [15:0] rotd [4];
    logic [3:0]  f;

    initial begin
        rd[0] = 16'h1111;
        rd[1] = 16'h2222;
        rd[2] = 16'h4444;
        rd[3] = 16'h8888;
        clear = 1'b0;
        req   = 4'b1111;

        // Reset held with every source requesting.
        for (int i = 0; i < 3; i++) tick("reset");
        chk("reset.grant", 32'(grant), 32'h0);
        chk("reset.busy", 32'(busy), 32'h0);
        chk("reset.data", 32'(display_data), 32'h0);
        clear = 1'b1;
        tick("reset_rel");
        chk("reset_rel.grant", 32'(grant), 32'h1);

        // Single source keeps the display across dwell expiry.
        do_reset();
        rd[2] = 16'h1234;
        req   = 4'b0100;
        for (int i = 0; i < 30; i++) begin
            tick("single");
            chk("single.grant", 32'(grant), 32'h4);
            chk("single.data", 32'(display_data), 32'h1234);
        end
        rd[2] = 16'h90AF;
        tick("single_upd");
        chk("single_upd.data", 32'(display_data), 32'h90AF);

        // Rotation 0 -> 1 -> 3 -> 0, eight cycles each.
        do_reset();
        rd[0] = 16'h1111;
        rd[1] = 16'h2222;
        rd[3] = 16'h8888;
        req   = 4'b1011;
        rot  = '{0, 1, 3, 0};
        rotd = '{16'h1111, 16'h2222, 16'h8888, 16'h1111};
        for (int i = 0; i < 32; i++) begin
            tick("rot");
            chk("rot.owner", 32'(owner), 32'(rot[i / 8]));
            chk("rot.data", 32'(display_data), 32'(rotd[i / 8]));
        end

        // Early release hands over on the next edge, then goes idle.
        do_reset();
        req = 4'b1010;
        for (int i = 0; i < 3; i++) tick("early");
        chk("early.own1", 32'(grant), 32'h2);
        req = 4'b1000;
        tick("early_rel");
        chk("early_rel.grant", 32'(grant), 32'h8);
        chk("early_rel.data", 32'(display_data), 32'h8888);
        req = 4'b0000;
        tick("early_idle");
        chk("early_idle.busy", 32'(busy), 32'h0);
        chk("early_idle.data", 32'(display_data), 32'h0);

        // Reset in the middle of a hold.
        do_reset();
        rd[2] = 16'h3333;
        req   = 4'b0100;
        for (int i = 0; i < 5; i++) tick("midrst");
        chk("midrst.own2", 32'(grant), 32'h4);
        clear = 1'b0;
        req   = 4'b0111;
        tick("midrst_clr");
        chk("midrst_clr.grant", 32'(grant), 32'h0);
        chk("midrst_clr.busy", 32'(busy), 32'h0);
        chk("midrst_clr.data", 32'(display_data), 32'h0);
        clear = 1'b1;
        tick("midrst_rel");
        chk("midrst_rel.grant", 32'(grant), 32'h1);

`ifdef SSEG_ARB_PRIO_EN
        // Urgent source preempts and the displaced owner resumes.
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 2; i++) tick("prio");
        req = 4'b0101;
        tick("prio_pre");
        chk("prio_pre.grant", 32'(grant), 32'h1);
        for (int i = 0; i < 3; i++) tick("prio_hold");
        req = 4'b0100;
        tick("prio_back");
        chk("prio_back.grant", 32'(grant), 32'h4);
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            f     = 4'($urandom) & 4'($urandom) & 4'($urandom);
            req   = req ^ f;
            rd[2'($urandom_range(3))] = 16'($urandom);
            clear = ($urandom_range(99) != 0);
            tick("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sseg_arbiter.md
# sseg_arbiter

Shares the single 4-digit seven-segment display between up to NREQ requesting sources. Each source raises a request with its 16-bit hex word. The block grants ownership round-robin with a minimum dwell time per owner, and drives the `display_data` input of the `sseg` scan driver from the current owner. It sits directly upstream of `sseg`, between the application logic and the display.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DWELL_CYCLES`, 50_000_000: cycles an owner keeps the display while others wait; minimum 2.
- `IDLE_DATA`, 16'h0000: value driven on `display_data` when nobody owns the display.
- `clk`, in, 1: system clock; all logic is on the rising edge.
- `clear`, in, 1: reset, synchronous and active-low.
- `req`, in, NREQ: per-source request; a source holds it high while it wants the display.
- `req_data`, in, 16*NREQ: source i's word is bits [16*i+15:16*i].
- `grant`, out, NREQ: one-hot ownership indication, or all zero.
- `owner`, out, $clog2(NREQ): index of the current owner; 0 when idle.
- `busy`, out, 1: high while any source owns the display.
- `display_data`, out, 16: word to the `sseg` driver.

## Operation
- FSM states are IDLE and HOLD.
- **Reset:**
  - State goes to IDLE.
  - `grant`=0, `owner`=0, `busy`=0, `display_data`=IDLE_DATA.
  - The round-robin pointer is set to NREQ-1, so req[0] wins first.
  - The dwell counter is set to 0.
- **IDLE:**
  - If `req`≠0, pick the first set bit searching upward from pointer+1 with wrap.
  - On that edge: load `grant`/`owner`, set `busy`=1, load the dwell counter with DWELL_CYCLES-1, set pointer=owner, go to HOLD.
- **HOLD, each cycle:**
  - `display_data` <= the owner's `req_data` slice, so data tracks the owner live.
- **HOLD, owner releases (req[owner]=0 sampled):**
  - If other requests are pending, re-arbitrate on the next edge with no idle gap.
  - Otherwise go to IDLE: `grant`=0, `busy`=0, `display_data`=IDLE_DATA.
  - A release ignores the remaining dwell.
- **HOLD, counter nonzero and owner still requesting:**
  - Decrement the counter.
- **HOLD, counter=0 and owner still requesting:**
  - If any other requester is pending, grant the next one round-robin after the owner.
  - If no other requester is pending, reload the counter and keep the owner.
- A requester is never starved. Worst-case wait is (NREQ-1)*DWELL_CYCLES+1 cycles.
- `req_data` of non-owners is ignored.
- A request that rises and falls while another source owns the display is lost. Sources must hold `req` until they see their `grant`.

## Timing
- Request to grant: 1 cycle. A `req` bit sampled high at edge t in IDLE gives `grant`/`busy` valid after edge t.
- On a grant edge, `display_data` loads the new owner's data on the same edge.
- After that, `req_data` changes reach `display_data` with 1-cycle latency.
- Under contention, an owner holds the display for exactly DWELL_CYCLES cycles, counted from the grant edge to the switch edge.
- Release to next grant: 1 cycle.
- Simultaneous expiry and release: treated as a release.
- Reset asserted mid-HOLD: all outputs return to their reset values on that edge. The in-flight owner gets no notification other than `grant` dropping.
- `grant` is always one-hot or zero and never glitches between edges, because all outputs are registered.

## Configuration
- `SSEG_ARB_PRIO_EN` defined:
  - req[0] is an urgent source. When sampled high while another source owns the display, it preempts on the next edge regardless of dwell.
  - The preempted source keeps its place because the pointer is not advanced.
  - req[0] itself still obeys dwell and release like any owner.
- Not defined:
  - req[0] is an ordinary round-robin participant.
  - No preemption logic is synthesized.

## Structure
- **`sseg_pkg`:**
  - `sseg_arb_state_t` enum (IDLE, HOLD).
  - `SSEG_DIGITS`=4 and `SSEG_WORD_W`=16.
  - Default IDLE_DATA constant.
- **`sseg_rr_pick`:** combinational sub-module.
  - Inputs: request vector, pointer, exclude-owner flag.
  - Outputs: found flag and the next index with wrap.
  - Instantiated once and reused by the IDLE, expiry and release paths.
- Dwell counter width is $clog2(DWELL_CYCLES).

## Test plan
All scenarios use NREQ=4 and DWELL_CYCLES=8.
- **Reset:** hold `clear`=0 for 3 cycles with req=4'b1111. Then `grant`=0, `busy`=0, `display_data`=16'h0000. After release, `grant`=4'b0001 one cycle later.
- **Single source:** req=4'b0100, req_data[2]=16'h1234, held for 30 cycles.
  - `grant`=4'b0100 throughout, with no switch at dwell expiry.
  - `display_data`=16'h1234.
  - Changing to 16'h90AF shows on `display_data` one cycle later.
- **Rotation:** req=4'b1011 held. Owners go 0→1→3→0, each exactly 8 cycles. `display_data` follows 16'h1111 / 16'h2222 / 16'h8888 per owner.
- **Early release:** owner 1 drops `req` at dwell cycle 3 while req[3] is pending. `grant`=4'b1000 on the next edge. With nothing pending, `busy`=0 and `display_data`=16'h0000.
- **Reset mid-HOLD:** pulse `clear` low for 1 cycle at dwell cycle 5 of owner 2. Outputs return to reset values. Re-arbitration restarts from req[0].
- **Preemption (`SSEG_ARB_PRIO_EN` defined):** owner 2 at dwell cycle 2, req[0] rises.
  - `grant`=4'b0001 on the next edge.
  - After req[0] releases, `grant` returns to 4'b0100.
